// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared constants and read-FSM state type for the SPI command buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int CMD_BYTE_W = 8;

`ifdef SPI_CMD_BUFFER_CKSUM_EN
    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_LOAD    = 2'd1,
        RD_PRESENT = 2'd2,
        RD_CKSUM   = 2'd3
    } rd_state_t;
`else
    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_LOAD    = 2'd1,
        RD_PRESENT = 2'd2
    } rd_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/spi_cmd_ram.sv
// ============================================================================
// Module   : spi_cmd_ram
// Brief    : DEPTH x W storage, one write port, one registered read port
//            with synchronous clear of the read register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Array contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/spi_cmd_buffer.sv
// ============================================================================
// Module   : spi_cmd_buffer
// Brief    : Packet-oriented command byte buffer feeding an SPI consumer.
//            Optional XOR checksum byte: define SPI_CMD_BUFFER_CKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_buffer
    import spi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CMD_BYTE_W-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  mem_enable,
    input  logic                  next_cmd,
    output logic [CMD_BYTE_W-1:0] data_out,
    output logic                  last_byte,
    output logic                  pkt_avail,
    output logic                  overflow
);

    localparam logic [AW:0] C_ONE   = (AW+1)'(1);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    // Pointers carry one extra bit so a full buffer differs from an empty one.
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_commit_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [AW:0]           r_base;
    logic [AW:0]           r_pkt_cnt;
    logic                  r_drop;
    logic                  r_overflow;
    logic                  r_pkt_avail;
    rd_state_t             r_state;
    logic [CMD_BYTE_W:0]   w_ram_q;
    logic [AW:0]           w_fill;
    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_commit;
    logic                  w_rd_done;
    logic [AW:0]           w_cnt_next;
`ifdef SPI_CMD_BUFFER_CKSUM_EN
    logic [CMD_BYTE_W-1:0] r_cksum;
`endif

    assign w_fill      = r_wr_ptr - r_base;
    assign w_full      = (w_fill == C_DEPTH);
    assign w_wr_accept = wr_en && !r_drop && !w_full;
    assign w_commit    = w_wr_accept && wr_last;

    spi_cmd_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (CMD_BYTE_W + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_accept),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({wr_last, wr_data}),
        .i_re    (r_state == RD_LOAD),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_ram_q)
    );

    // A byte arriving at a full buffer kills the whole packet in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_drop       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (wr_en) begin
            if (r_drop) begin
                if (wr_last) begin
                    r_drop <= 1'b0;
                end
            end else if (w_full) begin
                r_wr_ptr   <= r_commit_ptr;
                r_overflow <= 1'b1;
                r_drop     <= !wr_last;
            end else begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
                if (wr_last) begin
                    r_commit_ptr <= r_wr_ptr + C_ONE;
                end
            end
        end
    end

    always_comb begin
        w_rd_done = 1'b0;
        if (mem_enable && next_cmd) begin
`ifdef SPI_CMD_BUFFER_CKSUM_EN
            w_rd_done = (r_state == RD_CKSUM);
`else
            w_rd_done = (r_state == RD_PRESENT) && w_ram_q[CMD_BYTE_W];
`endif
        end
    end

    always_comb begin
        w_cnt_next = r_pkt_cnt;
        if (w_commit && !w_rd_done) begin
            w_cnt_next = r_pkt_cnt + C_ONE;
        end else if (w_rd_done && !w_commit) begin
            w_cnt_next = r_pkt_cnt - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt   <= '0;
            r_pkt_avail <= 1'b0;
        end else begin
            r_pkt_cnt   <= w_cnt_next;
            r_pkt_avail <= (w_cnt_next != '0);
        end
    end

    // r_base marks the first byte of the packet being read; a session that
    // ends mid-packet rewinds to it so the packet is replayed in full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RD_IDLE;
            r_rd_ptr <= '0;
            r_base   <= '0;
`ifdef SPI_CMD_BUFFER_CKSUM_EN
            r_cksum  <= '0;
`endif
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (mem_enable && r_pkt_avail) begin
                        r_state <= RD_LOAD;
`ifdef SPI_CMD_BUFFER_CKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                end
                RD_LOAD: begin
                    if (!mem_enable) begin
                        r_rd_ptr <= r_base;
                        r_state  <= RD_IDLE;
                    end else begin
                        r_state <= RD_PRESENT;
                    end
                end
                RD_PRESENT: begin
                    if (!mem_enable) begin
                        r_rd_ptr <= r_base;
                        r_state  <= RD_IDLE;
                    end else if (next_cmd) begin
                        r_rd_ptr <= r_rd_ptr + C_ONE;
`ifdef SPI_CMD_BUFFER_CKSUM_EN
                        r_cksum  <= r_cksum ^ w_ram_q[CMD_BYTE_W-1:0];
                        r_state  <= w_ram_q[CMD_BYTE_W] ? RD_CKSUM : RD_LOAD;
`else
                        if (w_ram_q[CMD_BYTE_W]) begin
                            r_base  <= r_rd_ptr + C_ONE;
                            r_state <= RD_IDLE;
                        end else begin
                            r_state <= RD_LOAD;
                        end
`endif
                    end
                end
`ifdef SPI_CMD_BUFFER_CKSUM_EN
                RD_CKSUM: begin
                    if (!mem_enable) begin
                        r_rd_ptr <= r_base;
                        r_state  <= RD_IDLE;
                    end else if (next_cmd) begin
                        r_base  <= r_rd_ptr;
                        r_state <= RD_IDLE;
                    end
                end
`endif
                default: r_state <= RD_IDLE;
            endcase
        end
    end

`ifdef SPI_CMD_BUFFER_CKSUM_EN
    assign data_out  = (r_state == RD_CKSUM) ? r_cksum : w_ram_q[CMD_BYTE_W-1:0];
    assign last_byte = (r_state == RD_CKSUM);
`else
    assign data_out  = w_ram_q[CMD_BYTE_W-1:0];
    assign last_byte = w_ram_q[CMD_BYTE_W];
`endif
    assign pkt_avail = r_pkt_avail;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_buffer.sv
// ============================================================================
// Module   : tb_spi_cmd_buffer
// Brief    : Scoreboard bench for spi_cmd_buffer (default build, DEPTH=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_cmd_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       mem_enable;
    logic       next_cmd;
    logic [7:0] data_out;
    logic       last_byte;
    logic       pkt_avail;
    logic       overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    spi_cmd_buffer #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .mem_enable (mem_enable),
        .next_cmd   (next_cmd),
        .data_out   (data_out),
        .last_byte  (last_byte),
        .pkt_avail  (pkt_avail),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic l, input bit keep);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = l;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (keep) sb_q.push_back({l, d});
    endtask

    // Byte is presented two edges after mem_enable rises or after a next_cmd pulse.
    task automatic rd(input string tag, input bit pulse);
        logic [8:0] e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got %0h expected nothing (scoreboard empty)", tag, {last_byte, data_out});
        end else begin
            e = sb_q.pop_front();
            check(tag, {7'd0, last_byte, data_out}, {7'd0, e});
        end
        if (pulse) begin
            next_cmd = 1'b1;
            @(negedge clk);
            next_cmd = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        wr_last    = 1'b0;
        mem_enable = 1'b0;
        next_cmd   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {8'd0, data_out}, 16'h0000);
        check("rst_last", {15'd0, last_byte}, 16'h0000);
        check("rst_avail", {15'd0, pkt_avail}, 16'h0000);
        check("rst_ovf", {15'd0, overflow}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Basic packet, with a stray next_cmd while idle
        wr(8'h0A, 1'b0, 1'b1);
        wr(8'h3F, 1'b0, 1'b1);
        wr(8'hC5, 1'b1, 1'b1);
        check("basic_avail_up", {15'd0, pkt_avail}, 16'h0001);
        next_cmd = 1'b1;
        @(negedge clk);
        next_cmd = 1'b0;
        check("idle_next_ignored", {15'd0, pkt_avail}, 16'h0001);
        mem_enable = 1'b1;
        for (int i = 0; i < 3; i++) rd("basic_byte", 1'b1);
        check("basic_avail_down", {15'd0, pkt_avail}, 16'h0000);
        mem_enable = 1'b0;
        @(negedge clk);

        // Session aborted after two bytes: the packet replays from its start
        wr(8'h0A, 1'b0, 1'b1);
        wr(8'h3F, 1'b0, 1'b1);
        wr(8'hC5, 1'b1, 1'b1);
        mem_enable = 1'b1;
        rd("replay_pre", 1'b1);
        rd("replay_pre", 1'b1);
        mem_enable = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.push_front({1'b0, 8'h3F});
        sb_q.push_front({1'b0, 8'h0A});
        check("replay_avail", {15'd0, pkt_avail}, 16'h0001);
        mem_enable = 1'b1;
        for (int i = 0; i < 3; i++) rd("replay_byte", 1'b1);
        check("replay_avail_down", {15'd0, pkt_avail}, 16'h0000);
        mem_enable = 1'b0;
        @(negedge clk);

        // Overflow: 10-byte packet fits, following 8-byte packet is dropped
        check("ovf_clear", {15'd0, overflow}, 16'h0000);
        for (int i = 0; i < 10; i++) wr(8'h10 + 8'(i), (i == 9), 1'b1);
        for (int i = 0; i < 8; i++) wr(8'h40 + 8'(i), (i == 7), 1'b0);
        check("ovf_set", {15'd0, overflow}, 16'h0001);
        wr(8'h60, 1'b0, 1'b1);
        wr(8'h61, 1'b1, 1'b1);
        mem_enable = 1'b1;
        for (int i = 0; i < 12; i++) rd("ovf_byte", 1'b1);
        check("ovf_avail_down", {15'd0, pkt_avail}, 16'h0000);
        check("ovf_sticky", {15'd0, overflow}, 16'h0001);
        mem_enable = 1'b0;
        @(negedge clk);

        // Commit of packet B coincides with the final next_cmd of packet A
        wr(8'hA1, 1'b0, 1'b1);
        wr(8'hA2, 1'b0, 1'b1);
        wr(8'hA3, 1'b1, 1'b1);
        wr(8'hB1, 1'b0, 1'b1);
        wr(8'hB2, 1'b0, 1'b1);
        mem_enable = 1'b1;
        rd("simul_a", 1'b1);
        rd("simul_a", 1'b1);
        rd("simul_a", 1'b0);
        next_cmd = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'hB3;
        wr_last  = 1'b1;
        @(negedge clk);
        next_cmd = 1'b0;
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        sb_q.push_back({1'b1, 8'hB3});
        check("simul_avail", {15'd0, pkt_avail}, 16'h0001);
        for (int i = 0; i < 3; i++) rd("simul_b", 1'b1);
        check("simul_avail_down", {15'd0, pkt_avail}, 16'h0000);
        mem_enable = 1'b0;
        @(negedge clk);

        // Reset with two packets stored, mid-read
        wr(8'hC1, 1'b0, 1'b1);
        wr(8'hC2, 1'b1, 1'b1);
        wr(8'hD1, 1'b1, 1'b1);
        mem_enable = 1'b1;
        rd("prerst_byte", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        check("mrst_avail", {15'd0, pkt_avail}, 16'h0000);
        check("mrst_data", {8'd0, data_out}, 16'h0000);
        check("mrst_last", {15'd0, last_byte}, 16'h0000);
        check("mrst_ovf", {15'd0, overflow}, 16'h0000);
        repeat (4) @(negedge clk);
        check("mrst_idle_data", {8'd0, data_out}, 16'h0000);
        check("mrst_idle_avail", {15'd0, pkt_avail}, 16'h0000);
        mem_enable = 1'b0;
        @(negedge clk);
        wr(8'hE1, 1'b0, 1'b1);
        wr(8'hE2, 1'b1, 1'b1);
        mem_enable = 1'b1;
        for (int i = 0; i < 2; i++) rd("postrst_byte", 1'b1);
        check("postrst_avail", {15'd0, pkt_avail}, 16'h0000);
        mem_enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
